// File: rtl/note_period_table_mc.sv
// note_period_table_mc: multi-channel note-to-period converter.
// Top-octave table plus octave shift, shared by N_CH channels via round-robin.
module note_period_table_mc #(
  parameter int N_CH         = 4,
  parameter int NOTE_W       = 7,
  parameter int PER_W        = 16,
  parameter int NOTE_MIN     = 12,
  parameter int NOTE_MAX     = 119,
  parameter int RESET_PERIOD = 1804
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic [N_CH-1:0]         req,
  input  logic [N_CH*NOTE_W-1:0]  note,
  output logic [N_CH-1:0]         ack,
  output logic [N_CH*PER_W-1:0]   period,
  output logic [N_CH-1:0]         upd,
  output logic [N_CH-1:0]         err,
  output logic                    busy
);

  localparam int RW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SW = PER_W + 18;
  localparam logic [NOTE_W-1:0] NMIN = NOTE_W'(NOTE_MIN);
  localparam logic [NOTE_W-1:0] NMAX = NOTE_W'(NOTE_MAX);
  localparam logic [NOTE_W-1:0] TWELVE = NOTE_W'(12);

  typedef enum logic [1:0] {IDLE, DIV, CALC} state_t;

  state_t                      state_q, state_d;
  logic [RW-1:0]               rr_q, rr_d;
  logic [RW-1:0]               ch_q, ch_d;
  logic [NOTE_W-1:0]           d_q, d_d;
  logic [NOTE_W-1:0]           q_q, q_d;
  logic                        oor_q, oor_d;
  logic [N_CH-1:0][PER_W-1:0]  period_q, period_d;
  logic [N_CH-1:0]             err_q, err_d;
  logic [N_CH-1:0]             ack_q, ack_d;
  logic [N_CH-1:0]             upd_q, upd_d;

  logic                        gnt_found;
  logic [RW-1:0]               gnt_ch;
  logic [NOTE_W-1:0]           gnt_note;
  logic [SW-1:0]               sum;
  logic [SW-1:0]               rnd;
  logic [SW-1:0]               shifted;
  logic [PER_W-1:0]            calc_p;

  function automatic logic [16:0] tbl(input logic [3:0] i);
    case (i)
      4'd0:    tbl = 17'd48537;
      4'd1:    tbl = 17'd45812;
      4'd2:    tbl = 17'd43241;
      4'd3:    tbl = 17'd40814;
      4'd4:    tbl = 17'd38524;
      4'd5:    tbl = 17'd36361;
      4'd6:    tbl = 17'd34321;
      4'd7:    tbl = 17'd32394;
      4'd8:    tbl = 17'd30576;
      4'd9:    tbl = 17'd28860;
      4'd10:   tbl = 17'd27240;
      4'd11:   tbl = 17'd25711;
      default: tbl = 17'd0;
    endcase
  endfunction

  // round-robin pick: first requesting channel at or after rr
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!gnt_found && req[idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = RW'(idx);
      end
    end
  end

  assign gnt_note = note[int'(gnt_ch)*NOTE_W +: NOTE_W];

  // table lookup and rounded octave shift
  always_comb begin
    sum     = SW'(tbl(d_q[3:0]));
    rnd     = (q_q == '0) ? '0 : (SW'(1) << (q_q - 1'b1));
    sum     = sum + rnd;
    shifted = sum >> q_q;
    calc_p  = shifted[PER_W-1:0];
  end

  // next-state and datapath control
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    ch_d     = ch_q;
    d_d      = d_q;
    q_d      = q_q;
    oor_d    = oor_q;
    period_d = period_q;
    err_d    = err_q;
    ack_d    = '0;
    upd_d    = '0;
    unique case (state_q)
      IDLE: begin
        // no grant in the ack cycle: the finished requester still holds req
        if (en && gnt_found && ack_q == '0) begin
          ch_d    = gnt_ch;
          rr_d    = (int'(gnt_ch) == N_CH - 1) ? '0 : gnt_ch + RW'(1);
          oor_d   = (gnt_note < NMIN) || (gnt_note > NMAX);
          d_d     = gnt_note - NMIN;
          q_d     = '0;
          state_d = ((gnt_note < NMIN) || (gnt_note > NMAX)) ? CALC : DIV;
        end
      end
      DIV: begin
        if (d_q >= TWELVE) begin
          d_d = d_q - TWELVE;
          q_d = q_q + 1'b1;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        period_d[ch_q] = oor_q ? '0 : calc_p;
        err_d[ch_q]    = oor_q;
        ack_d[ch_q]    = 1'b1;
        upd_d[ch_q]    = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and per-channel result registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rr_q    <= '0;
      ch_q    <= '0;
      d_q     <= '0;
      q_q     <= '0;
      oor_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) period_q[i] <= PER_W'(RESET_PERIOD);
      err_q   <= '0;
      ack_q   <= '0;
      upd_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      ch_q     <= ch_d;
      d_q      <= d_d;
      q_q      <= q_d;
      oor_q    <= oor_d;
      period_q <= period_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      upd_q    <= upd_d;
    end
  end

  assign period = period_q;
  assign ack    = ack_q;
  assign upd    = upd_q;
  assign err    = err_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_note_period_table_mc.sv
// tb_note_period_table_mc: directed checks of note_period_table_mc.
// Latency counted in cycles after the grant edge, ack cycle included.
module tb_note_period_table_mc;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [3:0]  req;
  logic [27:0] note;
  logic [3:0]  ack;
  logic [63:0] period;
  logic [3:0]  upd;
  logic [3:0]  err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  note_period_table_mc dut (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .req    (req),
    .note   (note),
    .ack    (ack),
    .period (period),
    .upd    (upd),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] per(input int c);
    return period[c*16 +: 16];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic conv(input int c, input int n, input int exp_p,
                      input int exp_e, input int exp_lat);
    int cyc;
    @(negedge clk);
    note[c*7 +: 7] = 7'(n);
    req[c] = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!ack[c] && cyc < 40);
    req[c] = 1'b0;
    chk($sformatf("ack_seen_ch%0d_n%0d", c, n), ack[c], 1);
    chk($sformatf("latency_ch%0d_n%0d", c, n), cyc, exp_lat);
    chk($sformatf("ack_vec_ch%0d_n%0d", c, n), ack, 32'(1 << c));
    chk($sformatf("upd_vec_ch%0d_n%0d", c, n), upd, 32'(1 << c));
    chk($sformatf("period_ch%0d_n%0d", c, n), per(c), exp_p);
    chk($sformatf("err_ch%0d_n%0d", c, n), err[c], exp_e);
    @(posedge clk); #1;
    chk($sformatf("ack_pulse_ch%0d_n%0d", c, n), ack, 0);
    chk($sformatf("upd_pulse_ch%0d_n%0d", c, n), upd, 0);
    chk($sformatf("busy_after_ch%0d_n%0d", c, n), busy, 0);
  endtask

  task automatic collect(input logic [3:0] r, input int cnt,
                         output int got [4]);
    int k;
    int cyc;
    for (int j = 0; j < 4; j++) got[j] = -1;
    k = 0;
    cyc = 0;
    @(negedge clk);
    req = r;
    while (k < cnt && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if ($countones(ack) > 1) chk("ack_multi", ack, 0);
      for (int j = 0; j < 4; j++) begin
        if (ack[j] && k < 4) begin
          got[k] = j;
          k++;
          req[j] = 1'b0;
        end
      end
    end
    chk("collect_count", k, cnt);
    @(posedge clk); #1;
  endtask

  initial begin
    int got [4];
    int seen;
    int cyc;
    rstn = 1'b0;
    en   = 1'b1;
    req  = '0;
    note = '0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 4; c++) chk($sformatf("rst_period%0d", c), per(c), 1804);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_upd", upd, 0);
    chk("rst_err", err, 0);
    rstn = 1'b1;

    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy || ack != 0 || upd != 0) seen++;
    end
    chk("idle_no_activity", seen, 0);

    conv(0, 12, 48537, 0, 3);
    chk("other_hold_p1", per(1), 1804);
    conv(0, 24, 24269, 0, 4);
    conv(2, 119, 100, 0, 11);
    conv(1, 69, 1804, 0, 7);
    conv(3, 23, 25711, 0, 3);
    conv(1, 5, 0, 1, 2);
    chk("err_only_ch1", err, 4'b0010);
    conv(1, 60, 3034, 0, 7);
    chk("err_clear_all", err, 0);
    chk("hold_p0", per(0), 24269);
    chk("hold_p2", per(2), 100);

    note[0*7 +: 7] = 7'd12;
    note[2*7 +: 7] = 7'd24;
    collect(4'b0101, 2, got);
    chk("rr2_first", got[0], 2);
    chk("rr2_second", got[1], 0);
    chk("rr2_p0", per(0), 48537);
    chk("rr2_p2", per(2), 24269);

    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    note[0*7 +: 7] = 7'd12;
    note[1*7 +: 7] = 7'd24;
    note[2*7 +: 7] = 7'd23;
    note[3*7 +: 7] = 7'd36;
    collect(4'b1111, 4, got);
    chk("all_order0", got[0], 0);
    chk("all_order1", got[1], 1);
    chk("all_order2", got[2], 2);
    chk("all_order3", got[3], 3);
    chk("all_p0", per(0), 48537);
    chk("all_p1", per(1), 24269);
    chk("all_p2", per(2), 25711);
    chk("all_p3", per(3), 12134);

    @(negedge clk);
    note[0*7 +: 7] = 7'd100;
    req[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    req[0] = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_upd", upd, 0);
    for (int c = 0; c < 4; c++) chk($sformatf("midrst_p%0d", c), per(c), 1804);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ack != 0 || upd != 0 || busy) seen++;
    end
    chk("midrst_quiet", seen, 0);
    chk("midrst_p0_hold", per(0), 1804);

    @(negedge clk);
    en = 1'b0;
    note[1*7 +: 7] = 7'd60;
    req[1] = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ack != 0 || upd != 0 || busy) seen++;
    end
    chk("en0_no_grant", seen, 0);
    chk("en0_p1", per(1), 1804);
    @(negedge clk);
    en = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!ack[1] && cyc < 40);
    req[1] = 1'b0;
    chk("en1_latency", cyc, 7);
    chk("en1_p1", per(1), 3034);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
